// File: rtl/wb_mem_master.sv
// Load/store unit front-end: one Wishbone classic access per request.
// Define WB_TIMEOUT_EN to abort bus cycles after TIMEOUT_CYC cycles.
module wb_mem_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              misalign, tmo, done, bus_err;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] lane, ext, wdat;
  logic [SEL_W-1:0]  mask;

  assign off     = addr_q[OFF_W-1:0];
  assign done    = wb_ack_i | wb_err_i | tmo;
  assign bus_err = wb_err_i | tmo;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;

  // BUS-cycle counter; held at zero outside BUS so every entry restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (state != BUS)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign tmo = (state == BUS) &&
               (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // Alignment check on the incoming request
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = (DATA_W == 32) ||
                          (|req_addr[2:0]);
    endcase
  end

  // Lane select, store replication and load extension
  always_comb begin
    lane = wb_dat_i >> {off, 3'b000};
    ext  = lane;
    mask = {SEL_W{1'b1}};
    wdat = wdata_q;
    case (size_q)
      2'b00: begin
        ext       = {DATA_W{lane[7] & ~uns_q}};
        ext[7:0]  = lane[7:0];
        mask      = SEL_W'(1);
        wdat      = {SEL_W{wdata_q[7:0]}};
      end
      2'b01: begin
        ext       = {DATA_W{lane[15] & ~uns_q}};
        ext[15:0] = lane[15:0];
        mask      = SEL_W'(3);
        wdat      = {(SEL_W/2){wdata_q[15:0]}};
      end
      2'b10: begin
        ext       = {DATA_W{lane[31] & ~uns_q}};
        ext[31:0] = lane[31:0];
        mask      = SEL_W'(15);
        wdat      = {(DATA_W/32){wdata_q[31:0]}};
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state and bus/response outputs
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = '0;
    wb_dat_o  = '0;
    wb_sel_o  = '0;
    rsp_rdata = rdata_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = misalign ? RESP : BUS;
      end
      BUS: begin
        busy     = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = we_q;
        wb_adr_o = {addr_q[ADDR_W-1:OFF_W],
                    {OFF_W{1'b0}}};
        wb_dat_o = wdat;
        wb_sel_o = mask << off;
        if (done)
          state_nx = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture and termination result; errors return zero data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      err_q   <= misalign;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == BUS && done) begin
      err_q   <= bus_err;
      rdata_q <= (bus_err || we_q) ? '0 : ext;
    end
  end

endmodule

// File: doc/wb_mem_master.md
WB_MEM_MASTER -- requirements
Module: wb_mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the bus data width; legal values are 32 and 64; SEL_W = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of cycles with strobe asserted before abort (used only with WB_TIMEOUT_EN).
REQ-004 SHALL have ports, one clock and one reset, the reset asynchronous and active-high:
 clk  in  1  clock, all logic on rising edge
 rst  in  1  asynchronous active-high reset
 req_valid  in  1  pipeline access request
 req_ready  out  1  request accepted this cycle
 req_we  in  1  1=store, 0=load
 req_addr  in  ADDR_W  byte address
 req_wdata  in  DATA_W  store data, right-aligned
 req_size  in  2  00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
 req_unsigned  in  1  zero-extend load data when 1
 rsp_valid  out  1  one-cycle completion pulse
 rsp_rdata  out  DATA_W  right-aligned, extended load data
 rsp_err  out  1  completion was an error, valid with rsp_valid
 busy  out  1  pipeline stall; high from accept until the rsp_valid cycle inclusive
 wb_adr_o  out  ADDR_W  bus-aligned address
 wb_dat_o  out  DATA_W  lane-replicated store data
 wb_dat_i  in  DATA_W  read data
 wb_sel_o  out  SEL_W  byte-lane selects
 wb_we_o / wb_stb_o / wb_cyc_o  out  1  Wishbone classic controls
 wb_ack_i / wb_err_i  in  1  slave termination

Function
REQ-005 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; req_ready = (state==IDLE).
REQ-006 SHALL, on req_valid in IDLE, register all request fields and enter BUS, or RESP with error if misaligned.
REQ-007 SHALL treat an access as misaligned when addr mod size-bytes != 0, or when req_size=11 with DATA_W=32; it SHALL issue no bus cycle and SHALL pulse rsp_err.
REQ-008 SHALL, in BUS, drive wb_cyc_o=wb_stb_o=1, wb_we_o=req_we, wb_adr_o=addr with the low log2(SEL_W) bits cleared, all held stable until termination.
REQ-009 SHALL set wb_sel_o to size-bytes consecutive ones shifted by the addr low bits, and wb_dat_o to the wdata low lane replicated across the bus.
REQ-010 SHALL terminate BUS on wb_ack_i or wb_err_i; cyc/stb SHALL drop the next cycle; on simultaneous ack and err, err SHALL win.
REQ-011 SHALL, in RESP, assert rsp_valid for exactly one cycle; on a load, rsp_rdata = selected lane shifted right and then sign- or zero-extended; on a store, rsp_rdata = 0.
REQ-012 SHALL have a latency of accept at cycle 0, stb at cycle 1, ack at cycle k≥1, and rsp_valid at k+1; the minimum throughput is one access per 3 cycles.
REQ-013 SHALL ignore wb_ack_i/wb_err_i outside BUS, and SHALL ignore req_valid outside IDLE.

Reset
REQ-014 SHALL, on rst assertion, immediately force wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err and busy to 0, force req_ready to 1 after reset, clear wb_adr_o, wb_dat_o, wb_sel_o and rsp_rdata to 0, and set state to IDLE, including when asserted mid-BUS.

Configuration
REQ-015 SHALL, with WB_TIMEOUT_EN defined, count BUS cycles and, at TIMEOUT_CYC cycles without termination, drop cyc/stb and enter RESP with rsp_err=1; the counter SHALL clear on every BUS entry.
REQ-016 SHALL, without WB_TIMEOUT_EN, contain no counter and wait in BUS indefinitely.

Verification
REQ-017 SHALL verify: DATA_W=32, LB addr 0x1003, wb_dat_i=0x80FF_FF00, ack at cycle 2 -> sel=1000, adr=0x1000, rsp_rdata=0xFFFF_FF80 at cycle 3.
REQ-018 SHALL verify: SH addr 0x2002, wdata=0x0000_ABCD -> sel=1100, wb_dat_o=0xABCD_ABCD, we=1; after ack, rsp_valid=1, rsp_err=0.
REQ-019 SHALL verify: LW addr 0x0006 -> no cyc at any cycle, rsp_valid=1 with rsp_err=1 at cycle 1.
REQ-020 SHALL verify: ack and err both high on cycle 3 -> rsp_err=1 at cycle 4, cyc low at cycle 4.
REQ-021 SHALL verify: WB_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> stb high for exactly 4 cycles, then rsp_err=1; without the macro, stb stays high for 100 or more cycles.
REQ-022 SHALL verify: rst asserted mid-BUS -> cyc/stb low in the same cycle; the next req_valid is accepted normally.
